vram_arbiter: RTL

- Owns the single-port 8 KB video RAM shared by the host CPU (Z80) and the MC6847 VGA display fetch.
- Decides which requester gets the RAM slot on every PIX_CLK cycle. Video reads have priority, with a bounded-starvation guarantee for the CPU.
- Drives the synchronous RAM directly. Returns read data to both requesters and generates the CPU WAIT signal.

---
 rtl/vram_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Purpose: arbitrates the single-port 8 KB VRAM between MC6847 video fetch (priority) and Z80 CPU.
// Latency: video data 2 edges after its slot; CPU write ack 1 edge, read ack 2 edges after grant.
// Backpressure: CPU stalled via cpu_wait; video has none, a 2-deep queue absorbs lost slots, overflow sets vid_overrun.
module vram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              PIX_CLK,
  input  logic              RESET_N,
  input  logic              vid_rd,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              vid_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {C_IDLE, C_WAIT, C_ISSUED, C_DONE} cpu_state_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  // video address queue
  logic [ADDR_W-1:0] r_fifo [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_cnt;
  logic              r_overrun;

  // slot arbitration and RAM port
  logic [3:0]        r_starve_cnt;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_ram_wdata;

  // video return pipeline
  logic              r_vslot1;
  logic              r_vslot2;
  logic              r_vid_valid;
  logic [DATA_W-1:0] r_vid_data;

  // CPU side
  cpu_state_t        r_state;
  logic              r_rd_ph;
  logic              r_cpu_we;
  logic [ADDR_W-1:0] r_cpu_addr;
  logic [DATA_W-1:0] r_cpu_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_cpu_ack;

  logic              w_cpu_pending;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_starved;
  logic              w_grant_cpu;
  logic              w_grant_vid;
  logic              w_pop;
  logic              w_push_req;
  logic              w_push;
  logic              w_drop;
  logic [ADDR_W-1:0] w_vid_slot_addr;

  assign w_cpu_pending = (r_state == C_WAIT);
  assign w_fifo_empty  = (r_cnt == 2'd0);
  assign w_fifo_full   = (r_cnt == 2'd2);
  assign w_starved     = w_cpu_pending && (r_starve_cnt == LP_LIMIT);
  assign w_grant_vid   = !w_starved && (!w_fifo_empty || vid_rd);
  assign w_grant_cpu   = w_cpu_pending && !w_grant_vid;
  assign w_pop         = w_grant_vid && !w_fifo_empty;
  // A strobe hitting an empty queue on a video slot bypasses the queue entirely.
  assign w_push_req    = vid_rd && !(w_grant_vid && w_fifo_empty);
  // A full queue that pops on the same edge still has room for the new address.
  assign w_push        = w_push_req && (!w_fifo_full || w_pop);
  assign w_drop        = w_push_req && w_fifo_full && !w_pop;
  assign w_vid_slot_addr = w_fifo_empty ? vid_addr : r_fifo[r_rd_ptr];

  assign vid_data    = r_vid_data;
  assign vid_valid   = r_vid_valid;
  assign vid_overrun = r_overrun;
  assign cpu_rdata   = r_cpu_rdata;
  assign cpu_ack     = r_cpu_ack;
  assign cpu_wait    = cpu_req && !r_cpu_ack && (r_state != C_DONE);
  assign ram_addr    = r_ram_addr;
  assign ram_we      = r_ram_we;
  assign ram_wdata   = r_ram_wdata;

  // Video queue bookkeeping and sticky overrun flag.
  always_ff @(posedge PIX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_cnt     <= 2'd0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= vid_addr;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  // Drive the RAM port for the winning slot and track CPU starvation.
  always_ff @(posedge PIX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ram_addr   <= '0;
      r_ram_we     <= 1'b0;
      r_ram_wdata  <= '0;
      r_starve_cnt <= 4'd0;
    end else begin
      r_ram_we <= 1'b0;
      if (w_grant_cpu) begin
        r_ram_addr   <= r_cpu_addr;
        r_ram_we     <= r_cpu_we;
        r_ram_wdata  <= r_cpu_wdata;
        r_starve_cnt <= 4'd0;
      end else if (w_grant_vid) begin
        r_ram_addr <= w_vid_slot_addr;
        if (w_cpu_pending && (r_starve_cnt != 4'hF))
          r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  // Video slot tag follows the RAM's one-cycle read latency, then captures data.
  always_ff @(posedge PIX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_vslot1    <= 1'b0;
      r_vslot2    <= 1'b0;
      r_vid_valid <= 1'b0;
      r_vid_data  <= '0;
    end else begin
      r_vslot1    <= w_grant_vid;
      r_vslot2    <= r_vslot1;
      r_vid_valid <= r_vslot2;
      if (r_vslot2) r_vid_data <= ram_rdata;
    end
  end

  // CPU request FSM: capture, wait for a slot, complete once, then wait for req release.
  always_ff @(posedge PIX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= C_IDLE;
      r_rd_ph     <= 1'b0;
      r_cpu_we    <= 1'b0;
      r_cpu_addr  <= '0;
      r_cpu_wdata <= '0;
      r_cpu_rdata <= '0;
      r_cpu_ack   <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      case (r_state)
        C_IDLE: begin
          if (cpu_req) begin
            r_cpu_we    <= cpu_we;
            r_cpu_addr  <= cpu_addr;
            r_cpu_wdata <= cpu_wdata;
            r_state     <= C_WAIT;
          end
        end
        C_WAIT: begin
          if (w_grant_cpu) begin
            r_rd_ph <= 1'b0;
            r_state <= C_ISSUED;
          end
        end
        C_ISSUED: begin
          if (r_cpu_we) begin
            r_cpu_ack <= 1'b1;
            r_state   <= C_DONE;
          end else if (!r_rd_ph) begin
            r_rd_ph <= 1'b1;
          end else begin
            r_cpu_rdata <= ram_rdata;
            r_cpu_ack   <= 1'b1;
            r_state     <= C_DONE;
          end
        end
        default: begin
          if (!cpu_req) r_state <= C_IDLE;
        end
      endcase
    end
  end

endmodule
